// File: rtl/trace_event_queue.sv
// Trace capture queue: round-robin arbitration of event channels into a
// timestamped circular buffer, with lossless (stall) or lossy (drop-and-count) modes.
module trace_event_queue #(
    parameter  int NUM_CHANNELS = 4,
    parameter  int PAYLOAD_BITS = 64,
    parameter  int DEPTH        = 16,
    parameter  int TS_BITS      = 32,
    parameter  int DROP_BITS    = 16,
    localparam int CH_BITS      = $clog2(NUM_CHANNELS),
    localparam int PTR_W        = $clog2(DEPTH) + 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic                                 lossy,
    input  logic [NUM_CHANNELS-1:0]              ch_valid,
    output logic [NUM_CHANNELS-1:0]              ch_ready,
    input  logic [NUM_CHANNELS*PAYLOAD_BITS-1:0] ch_payload,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [TS_BITS-1:0]                   out_timestamp,
    output logic [CH_BITS-1:0]                   out_channel,
    output logic [PAYLOAD_BITS-1:0]              out_payload,
    output logic [PTR_W-1:0]                     occupancy,
    output logic [DROP_BITS-1:0]                 drop_count,
    input  logic                                 drop_clear
);

    localparam int AW    = PTR_W - 1;
    localparam int REC_W = TS_BITS + CH_BITS + PAYLOAD_BITS;
    localparam int CNT_W = $clog2(NUM_CHANNELS + 1);
    localparam int SUM_W = DROP_BITS + CNT_W;
    localparam logic [SUM_W-1:0] DROP_MAX = SUM_W'({DROP_BITS{1'b1}});

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_CHANNELS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [DROP_BITS-1:0] sat_add(input logic [DROP_BITS-1:0] base,
                                                     input logic [CNT_W-1:0]     inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(inc);
        if (sum > DROP_MAX) begin
            return '1;
        end
        return sum[DROP_BITS-1:0];
    endfunction

    logic [REC_W-1:0]        mem [DEPTH];
    logic [TS_BITS-1:0]      ts;
    logic [CH_BITS-1:0]      rr;
    logic [CH_BITS-1:0]      rr_next;
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic                    full;
    logic                    pop;
    logic                    can_enq;
    logic                    enq;
    logic [CH_BITS-1:0]      win;
    logic                    found;
    int                      idx;
    logic [NUM_CHANNELS-1:0] win_mask;
    logic [NUM_CHANNELS-1:0] dropped;
    logic [PAYLOAD_BITS-1:0] win_payload;

    assign full      = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);
    assign out_valid = (head != tail);
    assign occupancy = tail - head;
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    assign can_enq   = enable && (!full || pop);
    assign enq       = (|ch_valid) && can_enq;

    always_comb begin
        win   = rr;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            idx = int'(rr) + k;
            if (idx >= NUM_CHANNELS) begin
                idx = idx - NUM_CHANNELS;
            end
            if (!found && ch_valid[idx]) begin
                win   = CH_BITS'(idx);
                found = 1'b1;
            end
        end
    end

    assign rr_next     = (win == CH_BITS'(NUM_CHANNELS - 1)) ? '0 : win + CH_BITS'(1);
    assign win_payload = ch_payload[PAYLOAD_BITS*int'(win) +: PAYLOAD_BITS];

    always_comb begin
        win_mask = '0;
        ch_ready = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            win_mask[i] = enq && (win == CH_BITS'(i));
            ch_ready[i] = (!enable || lossy) ? 1'b1 : ((win == CH_BITS'(i)) && can_enq);
        end
    end

    // Only lossy capture counts losses; a disabled queue silently discards.
    assign dropped = (enable && lossy) ? (ch_valid & ~win_mask) : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts         <= '0;
            rr         <= '0;
            head       <= '0;
            tail       <= '0;
            drop_count <= '0;
        end else begin
            ts <= ts + TS_BITS'(1);
            if (enq) begin
                tail <= tail + PTR_W'(1);
                rr   <= rr_next;
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            drop_count <= sat_add(drop_clear ? '0 : drop_count, popcount(dropped));
        end
    end

    // Record storage carries no reset; validity is tracked purely by the pointers.
    always_ff @(posedge clock) begin
        if (enq) begin
            mem[tail[AW-1:0]] <= {ts, win, win_payload};
        end
    end

    assign {out_timestamp, out_channel, out_payload} = mem[head[AW-1:0]];

endmodule
